// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX bypass select, store-data forward, long-op scoreboard and ID stall
module hazard_scoreboard #(
  parameter int NSRC   = 2,
  parameter int NSTAGE = 2,
  parameter int NREG   = 32,
  parameter int RAW    = 5,
  parameter int LATW   = 4,
  parameter int CNTW   = 16,
  localparam int SELW  = $clog2(NSTAGE + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSTAGE*RAW-1:0]  stg_rd,
  input  logic [NSTAGE-1:0]      stg_we,
  input  logic [NSRC*RAW-1:0]    ex_rs,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  input  logic [RAW-1:0]         me_rs2,
  input  logic                   me_mem_write,
  output logic                   forward_data,
  input  logic [NSRC*RAW-1:0]    id_rs,
  input  logic [NSRC-1:0]        id_rs_used,
  input  logic [RAW-1:0]         id_rd,
  input  logic                   id_we,
  input  logic                   id_is_long,
  input  logic [RAW-1:0]         ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   long_issue,
  input  logic [RAW-1:0]         long_rd,
  input  logic [LATW-1:0]        long_lat,
  output logic                   long_busy,
  output logic                   long_done,
  output logic [RAW-1:0]         long_done_rd,
  input  logic                   flush,
  output logic                   stall,
  output logic [CNTW-1:0]        stall_cnt
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            state_q, state_d;
  logic [LATW-1:0]   cnt_q, cnt_d;
  logic [RAW-1:0]    rd_q, rd_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [LATW-1:0]   lat_load;
  logic              load_use, sb_raw, sb_waw, st_hazard;

  // Bypass select: scan oldest to youngest so the youngest matching stage overrides
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (stg_we[k] && (stg_rd[k*RAW +: RAW] != '0) &&
            (stg_rd[k*RAW +: RAW] == ex_rs[i*RAW +: RAW])) begin
          fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
        end
      end
    end
  end

  assign forward_data = stg_we[NSTAGE-1] && (stg_rd[(NSTAGE-1)*RAW +: RAW] != '0) &&
                        (stg_rd[(NSTAGE-1)*RAW +: RAW] == me_rs2) && me_mem_write;

  // Zero latency is treated as one cycle
  assign lat_load = (long_lat == '0) ? '0 : long_lat - LATW'(1);

  // Long-unit tracker next state; done cycle may accept the next issue without a bubble
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    long_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (long_issue) begin
          state_d = S_BUSY;
          cnt_d   = lat_load;
          rd_d    = long_rd;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          long_done = 1'b1;
          if (long_issue) begin
            cnt_d = lat_load;
            rd_d  = long_rd;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - LATW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign long_busy    = (state_q == S_BUSY) && (cnt_q != '0);
  assign long_done_rd = long_done ? rd_q : '0;

  // Pending scoreboard: clear on completion first so a same-cycle reissue keeps the bit
  always_comb begin
    pending_d = pending_q;
    if (long_done) pending_d[rd_q] = 1'b0;
    if (long_issue) pending_d[long_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // ID hazard detection; flush kills the ID instruction so it never stalls
  always_comb begin
    load_use = 1'b0;
    sb_raw   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_rs_used[i]) begin
        if (ex_mem_read && (ex_rd != '0) && (ex_rd == id_rs[i*RAW +: RAW])) load_use = 1'b1;
        if ((id_rs[i*RAW +: RAW] != '0) && pending_q[id_rs[i*RAW +: RAW]]) sb_raw = 1'b1;
      end
    end
    sb_waw    = id_we && (id_rd != '0) && pending_q[id_rd];
    st_hazard = id_is_long && long_busy;
    stall     = !flush && (load_use || sb_raw || sb_waw || st_hazard);
  end

  // Saturating stall-cycle counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNTW'(1);
  end

  assign stall_cnt = stall_cnt_q;

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      pending_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  stg_rd;
  logic [1:0]  stg_we;
  logic [9:0]  ex_rs;
  logic [3:0]  fwd_sel;
  logic [4:0]  me_rs2;
  logic        me_mem_write, forward_data;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_we, id_is_long;
  logic [4:0]  ex_rd;
  logic        ex_mem_read, long_issue;
  logic [4:0]  long_rd;
  logic [3:0]  long_lat;
  logic        long_busy, long_done;
  logic [4:0]  long_done_rd;
  logic        flush, stall;
  logic [15:0] stall_cnt;

  logic [14:0] s3_stg_rd;
  logic [2:0]  s3_stg_we;
  logic [14:0] s3_ex_rs;
  logic [5:0]  s3_fwd_sel;
  logic [14:0] s3_id_rs;
  logic [2:0]  s3_id_rs_used;
  logic        s3_forward_data, s3_long_busy, s3_long_done, s3_stall;
  logic [4:0]  s3_long_done_rd;
  logic [15:0] s3_stall_cnt;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .stg_rd(stg_rd), .stg_we(stg_we), .ex_rs(ex_rs), .fwd_sel(fwd_sel),
    .me_rs2(me_rs2), .me_mem_write(me_mem_write), .forward_data(forward_data),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we), .id_is_long(id_is_long),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .long_issue(long_issue), .long_rd(long_rd),
    .long_lat(long_lat), .long_busy(long_busy), .long_done(long_done), .long_done_rd(long_done_rd),
    .flush(flush), .stall(stall), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.NSRC(3), .NSTAGE(3)) dut3 (
    .clk(clk), .rst(rst), .stg_rd(s3_stg_rd), .stg_we(s3_stg_we), .ex_rs(s3_ex_rs), .fwd_sel(s3_fwd_sel),
    .me_rs2(me_rs2), .me_mem_write(me_mem_write), .forward_data(s3_forward_data),
    .id_rs(s3_id_rs), .id_rs_used(s3_id_rs_used), .id_rd(id_rd), .id_we(id_we), .id_is_long(id_is_long),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .long_issue(long_issue), .long_rd(long_rd),
    .long_lat(long_lat), .long_busy(s3_long_busy), .long_done(s3_long_done), .long_done_rd(s3_long_done_rd),
    .flush(flush), .stall(s3_stall), .stall_cnt(s3_stall_cnt)
  );

  typedef struct { int cyc; logic [4:0] rd; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Completion scoreboard: every long_done must match the oldest expected issue
  always @(negedge clk) begin
    if (long_done) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL long_done_spurious: got done rd=%0d at cycle %0d, required no completion", long_done_rd, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (long_done_rd !== mon_e.rd || cyc != mon_e.cyc) begin
          miscompares++;
          $display("FAIL long_done_match: got rd=%0d cycle=%0d, required rd=%0d cycle=%0d", long_done_rd, cyc, mon_e.rd, mon_e.cyc);
        end
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL long_done_missing: got none by cycle %0d, required rd=%0d at cycle %0d", cyc, exp_q[0].rd, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  end

  task automatic idle_inputs();
    stg_rd = '0; stg_we = '0; ex_rs = '0; me_rs2 = '0; me_mem_write = 1'b0;
    id_rs = '0; id_rs_used = '0; id_rd = '0; id_we = 1'b0; id_is_long = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; long_issue = 1'b0; long_rd = '0; long_lat = '0; flush = 1'b0;
    s3_stg_rd = '0; s3_stg_we = '0; s3_ex_rs = '0; s3_id_rs = '0; s3_id_rs_used = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] lat);
    long_issue = 1'b1; long_rd = rd; long_lat = lat;
    exp_q.push_back('{cyc + ((lat == 0) ? 1 : int'(lat)), rd});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk); #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b, required 0", stall); end
    vectors++; if (long_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", long_busy); end
    vectors++; if (long_done !== 1'b0 || long_done_rd !== 5'd0) begin miscompares++; $display("FAIL reset_done: got %b/%0d, required 0/0", long_done, long_done_rd); end
    vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d, required 0", stall_cnt); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_forward();
    logic [1:0] t_we [5];
    logic [9:0] t_rd [5];
    logic [9:0] t_rs [5];
    logic [3:0] t_sel [5];
    logic [1:0] f_we [5];
    logic [9:0] f_rd [5];
    logic [4:0] f_rs2 [5];
    logic       f_mw [5];
    logic       f_exp [5];
    t_we = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    t_rd = '{{5'd5, 5'd5}, {5'd5, 5'd5}, {5'd0, 5'd0}, {5'd4, 5'd3}, {5'd9, 5'd8}};
    t_rs = '{{5'd5, 5'd5}, {5'd6, 5'd5}, {5'd0, 5'd0}, {5'd3, 5'd4}, {5'd8, 5'd9}};
    t_sel = '{{2'd1, 2'd1}, {2'd0, 2'd2}, {2'd0, 2'd0}, {2'd1, 2'd0}, {2'd1, 2'd2}};
    f_we = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    f_rd = '{{5'd6, 5'd0}, {5'd6, 5'd0}, {5'd0, 5'd0}, {5'd6, 5'd0}, {5'd0, 5'd6}};
    f_rs2 = '{5'd6, 5'd6, 5'd0, 5'd6, 5'd6};
    f_mw = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    f_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      stg_we = t_we[n]; stg_rd = t_rd[n]; ex_rs = t_rs[n];
      #1;
      vectors++;
      if (fwd_sel !== t_sel[n]) begin miscompares++; $display("FAIL fwd_sel[%0d]: got %b, required %b", n, fwd_sel, t_sel[n]); end
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      stg_we = f_we[n]; stg_rd = f_rd[n]; me_rs2 = f_rs2[n]; me_mem_write = f_mw[n];
      #1;
      vectors++;
      if (forward_data !== f_exp[n]) begin miscompares++; $display("FAIL forward_data[%0d]: got %b, required %b", n, forward_data, f_exp[n]); end
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    logic [9:0] t_rs [4];
    logic [1:0] t_used [4];
    logic [4:0] t_exrd [4];
    logic       t_stall [4];
    t_rs = '{{5'd0, 5'd7}, {5'd0, 5'd7}, {5'd7, 5'd0}, {5'd0, 5'd0}};
    t_used = '{2'b01, 2'b00, 2'b10, 2'b11};
    t_exrd = '{5'd7, 5'd7, 5'd7, 5'd0};
    t_stall = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      ex_mem_read = 1'b1; ex_rd = t_exrd[n]; id_rs = t_rs[n]; id_rs_used = t_used[n];
      #1;
      vectors++;
      if (stall !== t_stall[n]) begin miscompares++; $display("FAIL load_use[%0d]: got %b, required %b", n, stall, t_stall[n]); end
      if (t_stall[n]) exp_cnt++;
    end
    @(negedge clk); idle_inputs(); #1;
    vectors++; if (stall_cnt !== 16'(exp_cnt)) begin miscompares++; $display("FAIL load_use_cnt: got %0d, required %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_long();
    @(negedge clk); issue(5'd9, 4'd3); #1;
    vectors++; if (stall !== 1'b0 || long_busy !== 1'b0) begin miscompares++; $display("FAIL long_issue_cycle: got stall=%b busy=%b, required 0/0", stall, long_busy); end
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk); idle_inputs(); id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01; #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL long_raw_stall T+%0d: got %b, required 1", j, stall); end
      vectors++; if (long_busy !== (j < 3)) begin miscompares++; $display("FAIL long_busy T+%0d: got %b, required %b", j, long_busy, (j < 3)); end
      exp_cnt++;
    end
    @(negedge clk); #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL long_raw_release: got %b, required 0", stall); end
    @(negedge clk); idle_inputs(); issue(5'd20, 4'd2);
    @(negedge clk); idle_inputs(); id_we = 1'b1; id_rd = 5'd20; #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall: got %b, required 1", stall); end
    exp_cnt++;
    @(negedge clk); id_rd = 5'd21; #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL waw_other_rd: got %b, required 0", stall); end
    @(negedge clk); id_rd = 5'd20; #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL waw_release: got %b, required 0", stall); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); issue(5'd10, 4'd2);
    @(negedge clk); idle_inputs(); id_is_long = 1'b1; #1;
    vectors++; if (stall !== 1'b1 || long_busy !== 1'b1) begin miscompares++; $display("FAIL struct_stall: got stall=%b busy=%b, required 1/1", stall, long_busy); end
    exp_cnt++;
    @(negedge clk); issue(5'd11, 4'd2); #1;
    vectors++; if (stall !== 1'b0 || long_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_done_cycle: got stall=%b busy=%b, required 0/0", stall, long_busy); end
    @(negedge clk); idle_inputs(); id_rs = {5'd0, 5'd10}; id_rs_used = 2'b01; #1;
    vectors++; if (stall !== 1'b0 || long_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_reload: got stall=%b busy=%b, required 0/1", stall, long_busy); end
    @(negedge clk); id_rs = {5'd0, 5'd11}; #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL b2b_second_pending: got %b, required 1", stall); end
    exp_cnt++;
    @(negedge clk); #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL b2b_second_release: got %b, required 0", stall); end
    @(negedge clk); idle_inputs(); issue(5'd12, 4'd0);
    @(negedge clk); issue(5'd12, 4'd1); id_rs = {5'd0, 5'd12}; id_rs_used = 2'b01; #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL lat0_pending: got %b, required 1", stall); end
    exp_cnt++;
    @(negedge clk); long_issue = 1'b0; #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL set_wins: got %b, required 1", stall); end
    exp_cnt++;
    @(negedge clk); #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL set_wins_release: got %b, required 0", stall); end
    @(negedge clk); idle_inputs(); #1;
    vectors++; if (stall_cnt !== 16'(exp_cnt)) begin miscompares++; $display("FAIL long_cnt: got %0d, required %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    @(negedge clk); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01; flush = 1'b1; #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b, required 0", stall); end
    @(negedge clk); idle_inputs(); #1;
    vectors++; if (stall_cnt !== 16'(exp_cnt)) begin miscompares++; $display("FAIL flush_cnt: got %0d, required %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_saturate();
    @(negedge clk); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    repeat (70000) @(negedge clk);
    #1;
    vectors++; if (stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL stall_cnt_saturate: got %h, required ffff", stall_cnt); end
    @(negedge clk); idle_inputs(); #1;
    vectors++; if (stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL stall_cnt_hold: got %h, required ffff", stall_cnt); end
  endtask

  task automatic test_reset_busy();
    @(negedge clk); issue(5'd13, 4'd5);
    @(negedge clk); idle_inputs();
    @(negedge clk); #1;
    vectors++; if (long_busy !== 1'b1) begin miscompares++; $display("FAIL rb_busy_before: got %b, required 1", long_busy); end
    rst = 1'b1; #2;
    exp_q.delete();
    exp_cnt = 0;
    vectors++; if (long_busy !== 1'b0 || long_done !== 1'b0) begin miscompares++; $display("FAIL rb_async_clear: got busy=%b done=%b, required 0/0", long_busy, long_done); end
    vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL rb_cnt_clear: got %0d, required 0", stall_cnt); end
    @(negedge clk); rst = 1'b0; id_rs = {5'd0, 5'd13}; id_rs_used = 2'b01; #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rb_pending_clear: got %b, required 0", stall); end
    @(negedge clk); idle_inputs();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_fwd3();
    @(negedge clk);
    s3_stg_we = 3'b111; s3_stg_rd = {5'd3, 5'd2, 5'd1}; s3_ex_rs = {5'd3, 5'd2, 5'd1}; #1;
    vectors++; if (s3_fwd_sel !== 6'b11_10_01) begin miscompares++; $display("FAIL fwd3_distinct: got %b, required 111001", s3_fwd_sel); end
    @(negedge clk);
    s3_stg_rd = {5'd4, 5'd4, 5'd4}; s3_ex_rs = {5'd4, 5'd4, 5'd4}; #1;
    vectors++; if (s3_fwd_sel !== 6'b01_01_01) begin miscompares++; $display("FAIL fwd3_youngest: got %b, required 010101", s3_fwd_sel); end
    @(negedge clk);
    s3_stg_we = 3'b100; #1;
    vectors++; if (s3_fwd_sel !== 6'b11_11_11) begin miscompares++; $display("FAIL fwd3_oldest: got %b, required 111111", s3_fwd_sel); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_long();
    test_back_to_back();
    test_flush();
    test_saturate();
    test_reset_busy();
    test_fwd3();
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL pending_completions: got %0d outstanding, required 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
